// File: rtl/seg_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment scan driver.
// Optional build macro SEG_LEAD_ZERO_BLANK_EN is consumed by seg_scan_driver.
package seg_pkg;

    localparam int DIGIT_W    = 4;
    localparam int MAX_DIGITS = 8;

    localparam logic [MAX_DIGITS-1:0] AN_ALL_OFF = {MAX_DIGITS{1'b1}};

    // Active-low one-hot anode pattern; bits at or above n stay off.
    function automatic logic [MAX_DIGITS-1:0] onehot_low(input logic [2:0] idx, input int n);
        logic [MAX_DIGITS-1:0] res;
        res = AN_ALL_OFF;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            res[i] = !((i < n) && (i == int'(idx)));
        end
        return res;
    endfunction

endpackage

// File: rtl/seg_tick_gen.sv
// Digit-slot prescaler: counts enabled cycles 0..DIV-1 and flags the last one.
module seg_tick_gen #(
    parameter int DIV = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_r;

    assign tick = en && (cnt_r == CNT_MAX);

    // Prescaler counter; frozen while the scan is disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (tick) begin
            cnt_r <= '0;
        end else if (en) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed hex display scanner with frame-boundary double buffering.
// Build macro SEG_LEAD_ZERO_BLANK_EN blanks leading-zero digits (digit 0 always lit).
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int DIGITS = 8,
    parameter int DIV    = 50000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      load,
    input  logic [DIGIT_W*DIGITS-1:0] din,
    output logic [DIGIT_W-1:0]        nibble,
    output logic [DIGITS-1:0]         an,
    output logic                      pending
);

    localparam int DW    = DIGIT_W * DIGITS;
    localparam int IDX_W = $clog2(DIGITS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    logic                  tick_s;
    logic                  wrap_s;
    logic [IDX_W-1:0]      idx_r;
    logic [IDX_W-1:0]      next_idx_s;
    logic [DW-1:0]         disp_r;
    logic [DW-1:0]         next_disp_s;
    logic [DW-1:0]         pend_val_r;
    logic [DW-1:0]         next_pend_val_s;
    logic                  pending_r;
    logic                  next_pending_s;
    logic [DIGITS-1:0]     blank_s;
    logic [MAX_DIGITS-1:0] an_full_s;
    logic [DIGITS-1:0]     next_an_s;
    logic [DIGIT_W-1:0]    nibble_r;
    logic [DIGITS-1:0]     an_r;

    seg_tick_gen #(.DIV(DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .tick  (tick_s)
    );

    assign wrap_s = tick_s && (idx_r == IDX_LAST);

    // Next digit index and load/commit arbitration; a load on the wrap edge bypasses the buffer.
    always_comb begin
        next_idx_s      = idx_r;
        next_disp_s     = disp_r;
        next_pend_val_s = pend_val_r;
        next_pending_s  = pending_r;
        if (tick_s) begin
            next_idx_s = (idx_r == IDX_LAST) ? '0 : idx_r + IDX_W'(1);
        end else begin
            next_idx_s = idx_r;
        end
        if (load && !wrap_s) begin
            next_pend_val_s = din;
            next_pending_s  = 1'b1;
        end else if (wrap_s && load) begin
            next_disp_s    = din;
            next_pending_s = 1'b0;
        end else if (wrap_s && pending_r) begin
            next_disp_s    = pend_val_r;
            next_pending_s = 1'b0;
        end else begin
            next_pending_s = pending_r;
        end
    end

`ifdef SEG_LEAD_ZERO_BLANK_EN
    // Slot i>0 is blanked when it and every higher digit of the shown value are zero.
    always_comb begin : lead_zero
        logic zero_above;
        zero_above = 1'b1;
        blank_s    = '0;
        for (int i = DIGITS - 1; i > 0; i--) begin
            zero_above = zero_above && (next_disp_s[i*DIGIT_W +: DIGIT_W] == 4'd0);
            blank_s[i] = zero_above;
        end
    end
`else
    assign blank_s = '0;
`endif

    // Anode pattern for the slot being entered this edge.
    always_comb begin
        an_full_s = onehot_low(3'(next_idx_s), DIGITS);
        if (en) begin
            next_an_s = an_full_s[DIGITS-1:0] | blank_s;
        end else begin
            next_an_s = AN_ALL_OFF[DIGITS-1:0];
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_r      <= '0;
            disp_r     <= '0;
            pend_val_r <= '0;
            pending_r  <= 1'b0;
            nibble_r   <= 4'd0;
            an_r       <= AN_ALL_OFF[DIGITS-1:0];
        end else begin
            idx_r      <= next_idx_s;
            disp_r     <= next_disp_s;
            pend_val_r <= next_pend_val_s;
            pending_r  <= next_pending_s;
            nibble_r   <= next_disp_s[int'(next_idx_s)*DIGIT_W +: DIGIT_W];
            an_r       <= next_an_s;
        end
    end

    assign nibble  = nibble_r;
    assign an      = an_r;
    assign pending = pending_r;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Randomized self-checking bench for seg_scan_driver (DIGITS=4, DIV=4),
// compared against a frame-position reference model.
module tb_seg_scan_driver;

    localparam int DIGITS = 4;
    localparam int DIV    = 4;
    localparam int FRAME  = DIGITS * DIV;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        en    = 1'b0;
    logic        load  = 1'b0;
    logic [15:0] din   = 16'h0000;
    logic [3:0]  nibble;
    logic [3:0]  an;
    logic        pending;

    seg_scan_driver #(.DIGITS(DIGITS), .DIV(DIV)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .load    (load),
        .din     (din),
        .nibble  (nibble),
        .an      (an),
        .pending (pending)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: position in frame counted in enabled cycles.
    int          m_t;
    logic [15:0] m_disp;
    logic [15:0] m_q[$];
    logic        m_en;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int slot();
        return (m_t / DIV) % DIGITS;
    endfunction

    function automatic logic [3:0] exp_an();
        logic [3:0]  one;
        logic [15:0] upper;
        upper = m_disp >> (4 * slot());
        one   = 4'b0001 << slot();
        if (!m_en) return 4'hF;
`ifdef SEG_LEAD_ZERO_BLANK_EN
        if (slot() > 0 && upper == 16'h0000) return 4'hF;
`endif
        return ~one;
    endfunction

    function automatic logic [3:0] exp_nib();
        logic [15:0] sh;
        sh = m_disp >> (4 * slot());
        return sh[3:0];
    endfunction

    task automatic model_reset();
        m_t    = 0;
        m_disp = 16'h0000;
        m_q.delete();
        m_en   = 1'b0;
    endtask

    task automatic cycle(input logic e, input logic l, input logic [15:0] d);
        logic tick;
        logic wrap;
        en   = e;
        load = l;
        din  = d;
        @(posedge clk);
        tick = e && (m_t % DIV == DIV - 1);
        wrap = tick && (slot() == DIGITS - 1);
        if (l && !wrap) begin
            m_q.push_back(d);
        end else if (wrap) begin
            if (l) m_disp = d;
            else if (m_q.size() > 0) m_disp = m_q[$];
            m_q.delete();
        end
        if (e) m_t = (m_t + 1) % FRAME;
        m_en = e;
        #1;
        check_val("an", {28'd0, an}, {28'd0, exp_an()});
        check_val("nibble", {28'd0, nibble}, {28'd0, exp_nib()});
        check_val("pending", {31'd0, pending}, {31'd0, m_q.size() > 0});
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b1, 1'b0, 16'h0000);
    endtask

    task automatic run_to(input int target);
        for (int k = 0; k < 2 * FRAME && m_t != target; k++) cycle(1'b1, 1'b0, 16'h0000);
    endtask

    task automatic async_reset_check(input string tag);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_val({tag, "_an"}, {28'd0, an}, 32'h0000000F);
        check_val({tag, "_nib"}, {28'd0, nibble}, 32'h0);
        check_val({tag, "_pend"}, {31'd0, pending}, 32'h0);
        @(posedge clk);
        #4;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [15:0] d;
        model_reset();
        #12;
        check_val("rst_an", {28'd0, an}, 32'h0000000F);
        check_val("rst_nib", {28'd0, nibble}, 32'h0);
        check_val("rst_pend", {31'd0, pending}, 32'h0);
        #10;
        rst_n = 1'b1;
        cycle(1'b1, 1'b0, 16'h0000);
        check_val("first_an", {28'd0, an}, 32'h0000000E);

        // Basic scan of 1234
        cycle(1'b1, 1'b1, 16'h1234);
        check_val("load_pend", {31'd0, pending}, 32'h1);
        idle(3 * FRAME);
        check_val("disp_1234", {16'd0, m_disp}, 32'h1234);

        // Mid-frame load while slot 1 shows
        run_to(DIV + 1);
        cycle(1'b1, 1'b1, 16'hABCD);
        idle(2 * FRAME);

        // Two loads in one frame: last wins
        run_to(1);
        cycle(1'b1, 1'b1, 16'h1111);
        cycle(1'b1, 1'b1, 16'h2222);
        idle(2 * FRAME);
        check_val("disp_2222", {16'd0, m_disp}, 32'h2222);

        // Load on the wrap edge while another value is pending
        run_to(3);
        cycle(1'b1, 1'b1, 16'h2222);
        run_to(FRAME - 1);
        cycle(1'b1, 1'b1, 16'h5555);
        check_val("wrap_load_pend", {31'd0, pending}, 32'h0);
        idle(FRAME);
        check_val("disp_5555", {16'd0, m_disp}, 32'h5555);

        // Enable gating mid-slot 2
        run_to(2 * DIV + 1);
        for (int k = 0; k < 10; k++) cycle(1'b0, 1'b0, 16'h0000);
        idle(2 * FRAME);

        // Async reset mid-slot, then recovery
        run_to(DIV + 2);
        async_reset_check("midrst");
        cycle(1'b1, 1'b0, 16'h0000);
        check_val("post_rst_an", {28'd0, an}, 32'h0000000E);

        // Leading-zero values
        cycle(1'b1, 1'b1, 16'h0005);
        idle(2 * FRAME);
        cycle(1'b1, 1'b1, 16'h0000);
        idle(2 * FRAME);
        cycle(1'b1, 1'b1, 16'h0340);
        idle(2 * FRAME);

        // Randomized traffic
        for (int k = 0; k < 1500; k++) begin
            d = 16'($urandom) >> (4 * $urandom_range(0, 3));
            cycle($urandom_range(0, 7) != 0, $urandom_range(0, 5) == 0, d);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
